// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and width helpers for the systolic tile sequencer.
package systolic_pkg;

  localparam int N_DEF = 4;
  localparam int K_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FEED  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic int feed_w(input int n, input int k);
    return (n + k > 1) ? $clog2(n + k) : 1;
  endfunction

  function automatic int drain_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_tile_sequencer_if.sv
// Start/feed/done handshake bundle between a tile controller and the sequencer.
interface systolic_tile_sequencer_if
  import systolic_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
);

  localparam int FW = feed_w(N, K);

  logic          i_start_valid;
  logic          o_start_ready;
  logic          i_stall;
  logic          o_arr_clr;
  logic [N-1:0]  o_row_en;
  logic [N-1:0]  o_col_en;
  logic [FW-1:0] o_feed_cnt;
  logic          o_done_valid;
  logic          i_done_ready;
  logic          o_busy;

  modport master (
    output i_start_valid, i_stall, i_done_ready,
    input  o_start_ready, o_arr_clr, o_row_en, o_col_en,
           o_feed_cnt, o_done_valid, o_busy
  );

  modport slave (
    input  i_start_valid, i_stall, i_done_ready,
    output o_start_ready, o_arr_clr, o_row_en, o_col_en,
           o_feed_cnt, o_done_valid, o_busy
  );

endinterface

// File: rtl/skew_mask_gen.sv
// Diagonal skew decode: lane i injects during skew steps i .. i+K-1.
module skew_mask_gen #(
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int FW = 3
) (
  input  logic [FW-1:0] t,
  input  logic          en,
  output logic [N-1:0]  mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (int'(t) >= i) && (int'(t) < i + K)) begin
        mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer for an N x N systolic array: clears accumulators, skews A/B
// injection over K+N-1 feed steps, drains N cycles, then holds the result handshake.
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input logic i_clk,
  input logic i_rst,
  systolic_tile_sequencer_if.slave bus
);

  localparam int FW = feed_w(N, K);
  localparam int DW = drain_w(N);
  localparam logic [FW-1:0] T_LAST = FW'(K + N - 2);
  localparam logic [DW-1:0] D_LAST = DW'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [FW-1:0] t;
  logic [FW-1:0] t_nxt;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nxt;
  logic          feeding;
  logic [N-1:0]  row_mask;
  logic [N-1:0]  col_mask;

  // A stalled feed step holds t, so every inject still happens once stall clears.
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    dcnt_nxt  = dcnt;
    case (state)
      ST_IDLE: begin
        if (bus.i_start_valid) begin
          state_nxt = ST_FEED;
          t_nxt     = '0;
        end
      end
      ST_FEED: begin
        if (!bus.i_stall) begin
          if (t == T_LAST) begin
            state_nxt = ST_DRAIN;
            t_nxt     = '0;
            dcnt_nxt  = '0;
          end else begin
            t_nxt = t + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (dcnt == D_LAST) begin
          state_nxt = ST_DONE;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.i_done_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        t_nxt     = '0;
        dcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      t     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  skew_mask_gen #(.N(N), .K(K), .FW(FW)) u_row_mask (
    .t    (t),
    .en   (feeding),
    .mask (row_mask)
  );

  skew_mask_gen #(.N(N), .K(K), .FW(FW)) u_col_mask (
    .t    (t),
    .en   (feeding),
    .mask (col_mask)
  );

  // Outputs take their idle values while reset is held, whatever state is stored.
  always_comb begin
    feeding           = (state == ST_FEED) && !bus.i_stall && !i_rst;
    bus.o_start_ready = (state == ST_IDLE) || i_rst;
    bus.o_arr_clr     = (state == ST_IDLE) && bus.i_start_valid && !i_rst;
    bus.o_row_en      = row_mask;
    bus.o_col_en      = col_mask;
    bus.o_feed_cnt    = ((state == ST_FEED) && !i_rst) ? t : '0;
    bus.o_done_valid  = (state == ST_DONE) && !i_rst;
    bus.o_busy        = (state != ST_IDLE) && !i_rst;
  end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: fixed timing table, multi-cycle corner
// sequences and a randomized run against a progress-counter reference model.
module tb_systolic_tile_sequencer;
  import systolic_pkg::*;

  localparam int N       = 4;
  localparam int K       = 4;
  localparam int FW      = $clog2(K + N);
  localparam int FEEDLEN = K + N - 1;

  typedef struct packed {
    logic          arr_clr;
    logic [N-1:0]  row_en;
    logic [N-1:0]  col_en;
    logic [FW-1:0] feed_cnt;
    logic          done_valid;
    logic          busy;
    logic          start_ready;
  } outs_t;

  typedef struct {
    logic  start;
    logic  stall;
    logic  done_ready;
    logic  rst;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  systolic_tile_sequencer_if #(.N(N), .K(K)) bus ();

  systolic_tile_sequencer #(.N(N), .K(K)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one progress count of unstalled cycles since start.
  bit m_active = 1'b0;
  int m_p      = 0;

  function automatic logic [N-1:0] skew(input int tt);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      if (tt >= i && tt < i + K) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic outs_t mkOut(input logic clr, input logic [N-1:0] row,
                                  input logic [N-1:0] col, input int cnt,
                                  input logic done, input logic busy, input logic ready);
    outs_t o;
    o.arr_clr     = clr;
    o.row_en      = row;
    o.col_en      = col;
    o.feed_cnt    = FW'(cnt);
    o.done_valid  = done;
    o.busy        = busy;
    o.start_ready = ready;
    return o;
  endfunction

  function automatic vec_t mkVec(input logic s, input logic st, input logic dr,
                                 input logic r, input outs_t e);
    vec_t v;
    v.start      = s;
    v.stall      = st;
    v.done_ready = dr;
    v.rst        = r;
    v.exp        = e;
    return v;
  endfunction

  function automatic outs_t modelOut(input logic s, input logic st, input logic r);
    outs_t o;
    o = '0;
    if (r) begin
      o.start_ready = 1'b1;
    end else if (!m_active) begin
      o.start_ready = 1'b1;
      o.arr_clr     = s;
    end else begin
      o.busy = 1'b1;
      if (m_p < FEEDLEN) begin
        o.feed_cnt = FW'(m_p);
        if (!st) begin
          o.row_en = skew(m_p);
          o.col_en = skew(m_p);
        end
      end else if (m_p == FEEDLEN + N) begin
        o.done_valid = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic modelStep(input logic s, input logic st, input logic dr, input logic r);
    if (r) begin
      m_active = 1'b0;
      m_p      = 0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        m_p      = 0;
      end
    end else if (m_p < FEEDLEN) begin
      if (!st) m_p++;
    end else if (m_p < FEEDLEN + N) begin
      m_p++;
    end else if (dr) begin
      m_active = 1'b0;
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.arr_clr     = bus.o_arr_clr;
    o.row_en      = bus.o_row_en;
    o.col_en      = bus.o_col_en;
    o.feed_cnt    = bus.o_feed_cnt;
    o.done_valid  = bus.o_done_valid;
    o.busy        = bus.o_busy;
    o.start_ready = bus.o_start_ready;
    return o;
  endfunction

  task automatic applyStimulus(input logic s, input logic st, input logic dr, input logic r);
    bus.i_start_valid = s;
    bus.i_stall       = st;
    bus.i_done_ready  = dr;
    rst               = r;
  endtask

  task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s @%0t: got clr=%b row=%b col=%b cnt=%0d done=%b busy=%b rdy=%b, expected clr=%b row=%b col=%b cnt=%0d done=%b busy=%b rdy=%b",
               name, $time, act.arr_clr, act.row_en, act.col_en, act.feed_cnt,
               act.done_valid, act.busy, act.start_ready, exp.arr_clr, exp.row_en,
               exp.col_en, exp.feed_cnt, exp.done_valid, exp.busy, exp.start_ready);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic runCycle(input logic s, input logic st, input logic dr, input logic r,
                          input string name, output outs_t act);
    applyStimulus(s, st, dr, r);
    @(negedge clk);
    act = sample();
    checkOutput(name, act, modelOut(s, st, r));
    modelStep(s, st, dr, r);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    outs_t        act;
    vec_t         tbl [14];
    logic [N-1:0] exp_mask [FEEDLEN];
    int           done_at;
    int           second_clr;
    int           done_cnt;
    logic         rs, rst_r, rdr, rstall;

    exp_mask = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    tbl[0] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, mkOut(1'b1, '0, '0, 0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < FEEDLEN; i++) begin
      tbl[1 + i] = mkVec(1'b0, 1'b0, 1'b0, 1'b0,
                         mkOut(1'b0, exp_mask[i], exp_mask[i], i, 1'b0, 1'b1, 1'b0));
    end
    for (int i = 8; i < 12; i++) begin
      tbl[i] = mkVec(1'b0, 1'b0, 1'b0, 1'b0, mkOut(1'b0, '0, '0, 0, 1'b0, 1'b1, 1'b0));
    end
    tbl[12] = mkVec(1'b0, 1'b0, 1'b1, 1'b0, mkOut(1'b0, '0, '0, 0, 1'b1, 1'b1, 1'b0));
    tbl[13] = mkVec(1'b0, 1'b0, 1'b0, 1'b0, mkOut(1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b1));

    // Reset, then the idle cycle right after it.
    runCycle(1'b0, 1'b0, 1'b0, 1'b1, "reset_hold", act);
    runCycle(1'b0, 1'b0, 1'b0, 1'b1, "reset_hold", act);
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, "after_reset", act);

    // Unstalled tile against hand-derived cycle-by-cycle expectations.
    for (int c = 0; c < 14; c++) begin
      applyStimulus(tbl[c].start, tbl[c].stall, tbl[c].done_ready, tbl[c].rst);
      @(negedge clk);
      checkOutput($sformatf("table_c%0d", c), sample(), tbl[c].exp);
      modelStep(tbl[c].start, tbl[c].stall, tbl[c].done_ready, tbl[c].rst);
      @(posedge clk);
      #1;
    end

    // Stall at t=2 for three cycles plus an ignored start during FEED.
    done_at = -1;
    for (int c = 0; c < 40; c++) begin
      runCycle((c == 0) || (c == 2), (c >= 3) && (c <= 5), 1'b0, 1'b0, "stall_seq", act);
      if (c == 4) checkInt("stall_hold_t", int'(act.feed_cnt), 2);
      if (act.done_valid) begin
        done_at = c;
        break;
      end
    end
    checkInt("stall_done_cycle", done_at, 15);
    for (int c = 0; c < 5; c++) begin
      runCycle(1'b0, 1'b0, 1'b0, 1'b0, "done_wait", act);
      checkInt("done_hold", int'(act.done_valid), 1);
    end
    runCycle(1'b0, 1'b0, 1'b1, 1'b0, "done_handshake", act);
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, "idle_after_done", act);
    checkInt("idle_after_done_busy", int'(act.busy), 0);

    // Reset during DRAIN abandons the tile.
    for (int c = 0; c < 10; c++) begin
      runCycle(c == 0, 1'b0, 1'b1, c == 9, "rst_drain_seq", act);
    end
    runCycle(1'b0, 1'b0, 1'b1, 1'b0, "rst_drain_next", act);
    checkInt("rst_drain_busy", int'(act.busy), 0);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      runCycle(1'b0, 1'b0, 1'b1, 1'b0, "rst_drain_quiet", act);
      if (act.done_valid) done_cnt++;
    end
    checkInt("no_done_after_rst", done_cnt, 0);

    // Back-to-back tiles with start and done_ready held high.
    second_clr = -1;
    for (int c = 0; c < 20; c++) begin
      runCycle(1'b1, 1'b0, 1'b1, 1'b0, "b2b_seq", act);
      if (c > 0 && act.arr_clr && second_clr < 0) second_clr = c;
    end
    checkInt("b2b_second_start", second_clr, 13);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      rs     = ($urandom_range(0, 3) == 0);
      rstall = ($urandom_range(0, 2) == 0);
      rdr    = 1'($urandom_range(0, 1));
      rst_r  = ($urandom_range(0, 63) == 0);
      runCycle(rs, rstall, rdr, rst_r, "random", act);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
